floatmul_pipe: RTL
==================

// Module: floatmul_pipe
// PURPOSE
//   Parametrised, fully pipelined IEEE-754-style floating-point multiplier; next generation of floatmul.
//   Joins two valid/ready operand streams (a, b) and issues one product per cycle on valid/ready stream o.
//   Generic exponent/mantissa widths and latency; round-to-nearest-even; denormals flushed to zero.
//   Sits behind svutest_req_payload_rsp_if channels in the test top, as its predecessor does.
// PARAMETERS
//   EXP_W    8   exponent field width (bias = 2**(EXP_W-1)-1)
//   MAN_W    23  stored mantissa width (hidden bit implicit); DATA_W = 1+EXP_W+MAN_W
//   LATENCY  3   pipeline stages, accept-to-o_valid cycles; legal range 2..8
// PORTS
//   clk      in   1       clock; all state updates on posedge
//   rst      in   1       reset, synchronous, active-high
//   busy     out  1       any pipeline stage holds a valid entry
//   a_valid  in   1       operand A valid
//   a_data   in   DATA_W  operand A {sign, exp, man}
//   a_ready  out  1       operand A accepted this cycle when a_valid & a_ready
//   b_valid  in   1       operand B valid
//   b_data   in   DATA_W  operand B
//   b_ready  out  1       operand B accepted this cycle when b_valid & b_ready
//   o_valid  out  1       product valid
//   o_data   out  DATA_W  product
//   o_ready  in   1       downstream accepts product
//   o_flags  out  4       {invalid, overflow, underflow, inexact}; only with FLOATMUL_FLAGS_EN
// BEHAVIOUR
//   - Reset: all stage valids 0; o_valid, busy, o_data, o_flags 0. rst mid-operation discards all in-flight entries, no output.
//   - Join: accept = stage0 free or advancing; a_ready = accept & b_valid; b_ready = accept & a_valid.
//     A and B always transfer together; a lone valid is never consumed.
//   - Stage k advances when stage k+1 empty or advancing; last stage advances on o_ready (bubble collapse).
//   - o_valid/o_data held stable while o_valid & ~o_ready.
//   - Latency: pair accepted at cycle N with o_ready high -> o_valid at N+LATENCY. Throughput 1/cycle. Order preserved.
//   - Capacity LATENCY entries; when full and o_ready low, a_ready=b_ready=0.
//   - Stage 1: unpack, sign = sa^sb, exp sum = ea+eb-bias (EXP_W+2 bits signed), (MAN_W+1)x(MAN_W+1) product.
//   - Final stage: normalise (product >= 2 -> shift right 1, exp+1), RNE on guard/round/sticky,
//     rounding carry-out renormalises, pack. Middle stages are retiming registers only.
//   - Denormal inputs (exp==0) treated as signed zero.
//   - Special cases (priority order):
//     any NaN in -> canonical qNaN {0, all-ones, 1<<(MAN_W-1)}, invalid;
//     Inf x 0 -> canonical qNaN, invalid;
//     Inf x nonzero -> signed Inf;
//     zero x finite -> signed zero, no flags.
//   - Result exp >= all-ones after rounding -> signed Inf, overflow+inexact.
//   - Result exp <= 0 -> signed zero, underflow+inexact; inexact set only if nonzero bits were dropped.
//   - busy = OR of stage valids, registered with the stages.
// CONFIGURATION
//   FLOATMUL_FLAGS_EN defined: o_flags port present, computed in the final stage, registered and stalled with o_data.
//   FLOATMUL_FLAGS_EN undefined: o_flags port and all flag logic absent; o_data identical in both builds.
// TESTING (defaults EXP_W=8, MAN_W=23, LATENCY=3)
//   a=0x40000000, b=0x40400000 -> o_data=0x40C00000 exactly 3 cycles after accept; flags 0.
//   a=0x3F800001, b=0x3F800001 -> 0x3F800002 (RNE), inexact=1;
//     a=0xC0000000, b=0x40400000 -> 0xC0C00000.
//   a=0x7F000000, b=0x7F000000 -> 0x7F800000, overflow+inexact;
//     a=0x00800000, b=0x3F000000 -> 0x00000000, underflow+inexact.
//   a=0x7F800000, b=0x00000000 -> 0x7FC00000, invalid;
//     a=0x7FA00000, b=0x3F800000 -> 0x7FC00000, invalid.
//   Stream 8 pairs, o_ready low cycles 2..12 -> a_ready low once 3 held;
//     all 8 products delivered in order, none lost or duplicated; busy falls 1 cycle after last handshake.
//   a_valid high with b_valid low for 5 cycles -> a_ready=0 throughout;
//     rst asserted with 2 entries in flight -> next cycle o_valid=0, busy=0, no output ever appears.

Source files
------------

// File: rtl/floatmul_pipe.sv
// floatmul_pipe: fully pipelined floating-point multiplier.
// Joins operand streams a and b, issues one product per cycle on stream o.
// Round-to-nearest-even; denormal inputs are treated as signed zero.
// Define FLOATMUL_FLAGS_EN to add the o_flags {invalid, overflow, underflow, inexact} port.
module floatmul_pipe #(
  parameter  int EXP_W   = 8,
  parameter  int MAN_W   = 23,
  parameter  int LATENCY = 3,
  localparam int DATA_W  = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data
`ifdef FLOATMUL_FLAGS_EN
  ,
  output logic [3:0]        o_flags
`endif
);

  localparam int PW      = 2 * MAN_W + 2;           // full significand product width
  localparam int XW      = EXP_W + 2;               // two's-complement working exponent
  localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam int LS      = LATENCY - 2;             // last retiming stage, feeds the output stage

  typedef enum logic [1:0] {SP_NORM, SP_NAN, SP_INF, SP_ZERO} spec_t;

  // Handshake: stage k may load when any stage from k to the end has a hole,
  // or when the output is being drained this cycle.
  logic [LATENCY-1:0] r_v, w_en, w_v_next;
  logic               w_fire;

  assign w_fire  = a_valid & b_valid & w_en[0];
  assign a_ready = w_en[0] & b_valid;
  assign b_ready = w_en[0] & a_valid;
  assign o_valid = r_v[LATENCY-1];
  assign busy    = |r_v;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_ctl
      assign w_en[gi] = o_ready | ~(&r_v[LATENCY-1:gi]);
      if (gi == 0) begin : g_first
        assign w_v_next[gi] = w_en[gi] ? w_fire : r_v[gi];
      end else begin : g_rest
        assign w_v_next[gi] = w_en[gi] ? r_v[gi-1] : r_v[gi];
      end
    end
  endgenerate

  // Stage valid bits; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) r_v <= '0;
    else     r_v <= w_v_next;
  end

  // Operand unpack and special-case classification.
  logic              w_sa, w_sb;
  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [MAN_W-1:0]  w_ma, w_mb;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  spec_t             w_spec0;
  logic [XW-1:0]     w_exp0;
  logic [PW-1:0]     w_prod0;

  assign {w_sa, w_ea, w_ma} = a_data;
  assign {w_sb, w_eb, w_mb} = b_data;
  assign w_a_zero = ~|w_ea;
  assign w_b_zero = ~|w_eb;
  assign w_a_nan  = (&w_ea) & (|w_ma);
  assign w_b_nan  = (&w_eb) & (|w_mb);
  assign w_a_inf  = (&w_ea) & ~(|w_ma);
  assign w_b_inf  = (&w_eb) & ~(|w_mb);
  assign w_exp0   = XW'(w_ea) + XW'(w_eb) - XW'(BIAS);
  assign w_prod0  = PW'({1'b1, w_ma}) * PW'({1'b1, w_mb});

  // Special-case priority: NaN, Inf x 0, Inf, zero.
  always_comb begin
    w_spec0 = SP_NORM;
    if (w_a_nan | w_b_nan)                                w_spec0 = SP_NAN;
    else if ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) w_spec0 = SP_NAN;
    else if (w_a_inf | w_b_inf)                           w_spec0 = SP_INF;
    else if (w_a_zero | w_b_zero)                         w_spec0 = SP_ZERO;
  end

  // First stage captures the raw product; later ones are pure retiming.
  logic              r_sign [LATENCY-1];
  logic [XW-1:0]     r_exp  [LATENCY-1];
  logic [PW-1:0]     r_prod [LATENCY-1];
  spec_t             r_spec [LATENCY-1];

  // Intermediate payload registers, stalled by their stage enables.
  always_ff @(posedge clk) begin
    if (w_en[0]) begin
      r_sign[0] <= w_sa ^ w_sb;
      r_exp[0]  <= w_exp0;
      r_prod[0] <= w_prod0;
      r_spec[0] <= w_spec0;
    end
    for (int k = 1; k < LATENCY - 1; k++) begin
      if (w_en[k]) begin
        r_sign[k] <= r_sign[k-1];
        r_exp[k]  <= r_exp[k-1];
        r_prod[k] <= r_prod[k-1];
        r_spec[k] <= r_spec[k-1];
      end
    end
  end

  // Normalise, round to nearest even, range-check and pack.
  logic [PW-2:0]     w_norm;
  logic [XW-1:0]     w_exp_n, w_exp_r;
  logic [MAN_W-1:0]  w_mant;
  logic              w_g, w_r, w_s, w_up, w_ovf, w_unf;
  logic [MAN_W:0]    w_mant_r;
  logic [DATA_W-1:0] w_data_f;

  always_comb begin
    // A product >= 2 has its leading one in the top bit; otherwise shift it up.
    w_norm   = r_prod[LS][PW-1] ? r_prod[LS][PW-2:0] : {r_prod[LS][PW-3:0], 1'b0};
    w_exp_n  = r_exp[LS] + XW'(r_prod[LS][PW-1]);
    w_mant   = w_norm[PW-2 -: MAN_W];
    w_g      = w_norm[MAN_W];
    w_r      = w_norm[MAN_W-1];
    w_s      = |w_norm[MAN_W-2:0];
    w_up     = w_g & (w_r | w_s | w_mant[0]);
    w_mant_r = {1'b0, w_mant} + (MAN_W+1)'(w_up);
    // Carry out of the mantissa leaves the field all-zero; only the exponent moves.
    w_exp_r  = w_exp_n + XW'(w_mant_r[MAN_W]);
    w_unf    = w_exp_r[XW-1] | (w_exp_r == '0);
    w_ovf    = ~w_exp_r[XW-1] & (w_exp_r >= XW'(EXP_MAX));
    w_data_f = {r_sign[LS], w_exp_r[EXP_W-1:0], w_mant_r[MAN_W-1:0]};
    case (r_spec[LS])
      SP_NAN:  w_data_f = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      SP_INF:  w_data_f = {r_sign[LS], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      SP_ZERO: w_data_f = {r_sign[LS], {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (w_ovf)      w_data_f = {r_sign[LS], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_unf) w_data_f = {r_sign[LS], {(EXP_W+MAN_W){1'b0}}};
      end
    endcase
  end

  // Output register: holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst)                    o_data <= '0;
    else if (w_en[LATENCY-1])   o_data <= w_data_f;
  end

`ifdef FLOATMUL_FLAGS_EN
  logic [3:0] w_flags;

  // Exception flags; a normal x normal product is never zero, so flushed results are inexact.
  always_comb begin
    w_flags = 4'b0000;
    if (r_spec[LS] == SP_NAN) w_flags = 4'b1000;
    else if (r_spec[LS] == SP_NORM) begin
      if (w_ovf)      w_flags = 4'b0101;
      else if (w_unf) w_flags = 4'b0011;
      else            w_flags = {3'b000, w_g | w_r | w_s};
    end
  end

  // Flags travel with o_data and stall with it.
  always_ff @(posedge clk) begin
    if (rst)                    o_flags <= '0;
    else if (w_en[LATENCY-1])   o_flags <= w_flags;
  end
`endif

endmodule
